// File: rtl/mem_pkg.sv
// Shared definitions for the RAM arbiter and its size/merge helper.
package mem_pkg;

    // Access size encodings; 2'b11 is handled as a word access.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Two requesters, so a one-bit port id.
    localparam int PORT_W = 1;
    typedef logic [PORT_W-1:0] port_id_t;

    // Arbiter sequencing: accept, touch the RAM, report completion.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_size_unit.sv
// Size-dependent store merge and load extraction for a 32-bit RAM word
// whose byte 0 sits at [7:0]. Purely combinational so the CPU's
// load/store path can reuse it.
module mem_size_unit
    import mem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [1:0]   size_i,
    input  logic [N-1:0] wdata_i,
    input  logic [N-1:0] rdata_i,
    output logic [N-1:0] wmerge_o,
    output logic [N-1:0] rextract_o
);

    // Keep bytes outside the access size from the current RAM contents;
    // zero-extend narrow loads.
    always_comb begin
        wmerge_o   = wdata_i;
        rextract_o = rdata_i;
        case (size_i)
            SIZE_BYTE: begin
                wmerge_o   = {rdata_i[N-1:8], wdata_i[7:0]};
                rextract_o = {{(N-8){1'b0}}, rdata_i[7:0]};
            end
            SIZE_HALF: begin
                wmerge_o   = {rdata_i[N-1:16], wdata_i[15:0]};
                rextract_o = {{(N-16){1'b0}}, rdata_i[15:0]};
            end
            default: begin
                wmerge_o   = wdata_i;
                rextract_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared RAM.
//
// Handshake: a request transfers on a cycle where req_valid_x and
// req_ready_x are both high. Ready is only ever raised in IDLE, for the
// single winning port, and is combinational from valid and state; a
// requester keeps valid and payload stable until it sees ready, and may
// drop valid beforehand without anything being captured. Completion is a
// one-cycle resp_valid_x pulse two cycles after the handshake, with no
// back-pressure. N must be 32.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         req_valid_0,
    output logic         req_ready_0,
    input  logic [N-1:0] req_addr_0,
    input  logic [N-1:0] req_wdata_0,
    input  logic         req_we_0,
    input  logic [1:0]   req_size_0,
    output logic         resp_valid_0,
    output logic [N-1:0] resp_rdata_0,

    input  logic         req_valid_1,
    output logic         req_ready_1,
    input  logic [N-1:0] req_addr_1,
    input  logic [N-1:0] req_wdata_1,
    input  logic         req_we_1,
    input  logic [1:0]   req_size_1,
    output logic         resp_valid_1,
    output logic [N-1:0] resp_rdata_1,

    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_we,
    input  logic [N-1:0] mem_rdata
);

    arb_state_e   state_q, state_d;
    port_id_t     last_grant_q, last_grant_d;
    port_id_t     cap_port_q, cap_port_d;
    logic [N-1:0] cap_addr_q, cap_addr_d;
    logic [N-1:0] cap_wdata_q, cap_wdata_d;
    logic         cap_we_q, cap_we_d;
    logic [1:0]   cap_size_q, cap_size_d;
    logic         mem_we_q, mem_we_d;
    logic [1:0]   resp_valid_q, resp_valid_d;
    logic [N-1:0] resp_rdata0_q, resp_rdata0_d;
    logic [N-1:0] resp_rdata1_q, resp_rdata1_d;

    port_id_t     winner;
    logic         handshake;
    logic [N-1:0] merged_word;
    logic [N-1:0] extracted_word;

    mem_size_unit #(.N(N)) u_size (
        .size_i     (cap_size_q),
        .wdata_i    (cap_wdata_q),
        .rdata_i    (mem_rdata),
        .wmerge_o   (merged_word),
        .rextract_o (extracted_word)
    );

    // Round-robin pick: a lone requester wins, a contested cycle goes to
    // the port that was not granted last.
    always_comb begin
        winner = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            winner = ~last_grant_q;
        end else if (req_valid_1) begin
            winner = 1'b1;
        end
    end

    assign handshake   = (state_q == ST_IDLE) && (req_valid_0 || req_valid_1);
    assign req_ready_0 = handshake && (winner == 1'b0);
    assign req_ready_1 = handshake && (winner == 1'b1);

    // RAM port comes straight from captured/registered state; outside a
    // store access the write word is just the captured store data.
    assign mem_addr     = cap_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_we_q ? merged_word : cap_wdata_q;
    assign resp_valid_0 = resp_valid_q[0];
    assign resp_valid_1 = resp_valid_q[1];
    assign resp_rdata_0 = resp_rdata0_q;
    assign resp_rdata_1 = resp_rdata1_q;

    // Next-state and next-output computation for the IDLE/ACCESS/RESP loop.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cap_port_d    = cap_port_q;
        cap_addr_d    = cap_addr_q;
        cap_wdata_d   = cap_wdata_q;
        cap_we_d      = cap_we_q;
        cap_size_d    = cap_size_q;
        mem_we_d      = 1'b0;
        resp_valid_d  = 2'b00;
        resp_rdata0_d = resp_rdata0_q;
        resp_rdata1_d = resp_rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    cap_port_d   = winner;
                    last_grant_d = winner;
                    if (winner == 1'b1) begin
                        cap_addr_d  = req_addr_1;
                        cap_wdata_d = req_wdata_1;
                        cap_we_d    = req_we_1;
                        cap_size_d  = req_size_1;
                        mem_we_d    = req_we_1;
                    end else begin
                        cap_addr_d  = req_addr_0;
                        cap_wdata_d = req_wdata_0;
                        cap_we_d    = req_we_0;
                        cap_size_d  = req_size_0;
                        mem_we_d    = req_we_0;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!cap_we_q) begin
                    if (cap_port_q == 1'b1) begin
                        resp_rdata1_d = extracted_word;
                    end else begin
                        resp_rdata0_d = extracted_word;
                    end
                end
                resp_valid_d[cap_port_q] = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight write and pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            cap_port_q    <= 1'b0;
            cap_addr_q    <= '0;
            cap_wdata_q   <= '0;
            cap_we_q      <= 1'b0;
            cap_size_q    <= 2'b00;
            mem_we_q      <= 1'b0;
            resp_valid_q  <= 2'b00;
            resp_rdata0_q <= '0;
            resp_rdata1_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cap_port_q    <= cap_port_d;
            cap_addr_q    <= cap_addr_d;
            cap_wdata_q   <= cap_wdata_d;
            cap_we_q      <= cap_we_d;
            cap_size_q    <= cap_size_d;
            mem_we_q      <= mem_we_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata0_q <= resp_rdata0_d;
            resp_rdata1_q <= resp_rdata1_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-addressed RAM model
// (64 bytes, filled with 0xAA on request, address wraps).
module tb_mem_arbiter;

  localparam int N = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_we;
  logic [1:0]   resp_valid;
  logic [N-1:0] req_addr [2];
  logic [N-1:0] req_wdata [2];
  logic [1:0]   req_size [2];
  logic [N-1:0] resp_rdata_0, resp_rdata_1;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
  logic         mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.N(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_0  (req_valid[0]),
    .req_ready_0  (req_ready[0]),
    .req_addr_0   (req_addr[0]),
    .req_wdata_0  (req_wdata[0]),
    .req_we_0     (req_we[0]),
    .req_size_0   (req_size[0]),
    .resp_valid_0 (resp_valid[0]),
    .resp_rdata_0 (resp_rdata_0),
    .req_valid_1  (req_valid[1]),
    .req_ready_1  (req_ready[1]),
    .req_addr_1   (req_addr[1]),
    .req_wdata_1  (req_wdata[1]),
    .req_we_1     (req_we[1]),
    .req_size_1   (req_size[1]),
    .resp_valid_1 (resp_valid[1]),
    .resp_rdata_1 (resp_rdata_1),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  // ---------------- RAM model ----------------
  logic [7:0] ram [64];
  logic       ram_clear;
  logic [5:0] ra;
  assign ra = mem_addr[5:0];
  assign mem_rdata = {ram[ra + 6'd3], ram[ra + 6'd2], ram[ra + 6'd1], ram[ra]};

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= 8'hAA;
    end else if (mem_we) begin
      ram[ra]        <= mem_wdata[7:0];
      ram[ra + 6'd1] <= mem_wdata[15:8];
      ram[ra + 6'd2] <= mem_wdata[23:16];
      ram[ra + 6'd3] <= mem_wdata[31:24];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_valid = 2'b00;
    req_we    = 2'b00;
    for (int p = 0; p < 2; p++) begin
      req_addr[p]  = '0;
      req_wdata[p] = '0;
      req_size[p]  = 2'b10;
    end
  endtask

  // Full reset with RAM refill; returns just after a posedge in IDLE.
  task automatic apply_reset();
    idle_inputs();
    rst_n     = 1'b0;
    ram_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ram_clear = 1'b0;
    rst_n     = 1'b1;
  endtask

  // One request on port p; called just after a posedge. Reports whether it
  // completed, the response latency in cycles after the handshake cycle,
  // the number of cycles mem_we was seen high, and the load data.
  task automatic do_access(input int p, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic we,
                           input logic [1:0] size, output logic [31:0] rdata,
                           output int lat, output int we_cnt, output bit ok);
    bit got_ready;
    ok = 1'b0; lat = -1; we_cnt = 0; rdata = '0; got_ready = 1'b0;
    req_addr[p] = addr; req_wdata[p] = wdata; req_we[p] = we;
    req_size[p] = size; req_valid[p] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (req_ready[p]) begin
        got_ready = 1'b1;
        break;
      end
    end
    if (!got_ready) begin
      req_valid[p] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_we) we_cnt++;
      if (resp_valid[p]) begin
        lat   = k;
        rdata = (p == 1) ? resp_rdata_1 : resp_rdata_0;
        ok    = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    ram_clear = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 00000000", mem_wdata); end
    n_checks++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    n_checks++; if ({resp_rdata_1, resp_rdata_0} !== 64'h0) begin n_fail++; $display("FAIL reset_resp_rdata: got %h/%h want 0/0", resp_rdata_1, resp_rdata_0); end
    @(posedge clk);
    #1;
    ram_clear = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready_idle: got %b want 00", req_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd; int lat, wc; bit ok;
    do_access(1, 32'd8, 32'h1122_3344, 1'b1, 2'b10, rd, lat, wc, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL word_store_done: got %b want 1", ok); end
    n_checks++; if (wc != 1) begin n_fail++; $display("FAIL word_store_we_cycles: got %0d want 1", wc); end
    do_access(1, 32'd8, 32'h0, 1'b0, 2'b10, rd, lat, wc, ok);
    n_checks++; if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL word_load_data: got %h want 11223344", rd); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL word_load_latency: got %0d want 2", lat); end
    n_checks++; if (wc != 0) begin n_fail++; $display("FAIL word_load_no_we: got %0d want 0", wc); end
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; int lat, wc; bit ok;
    do_access(1, 32'd9, 32'h0000_00EE, 1'b1, 2'b00, rd, lat, wc, ok);
    n_checks++; if (wc != 1) begin n_fail++; $display("FAIL byte_store_we_cycles: got %0d want 1", wc); end
    do_access(1, 32'd8, 32'h0, 1'b0, 2'b10, rd, lat, wc, ok);
    n_checks++; if (rd !== 32'h1122_EE44) begin n_fail++; $display("FAIL byte_store_merge: got %h want 1122ee44", rd); end
    // size 2'b11 behaves as a word
    do_access(1, 32'd8, 32'h0, 1'b0, 2'b11, rd, lat, wc, ok);
    n_checks++; if (rd !== 32'h1122_EE44) begin n_fail++; $display("FAIL size3_word_load: got %h want 1122ee44", rd); end
  endtask

  task automatic test_half_store();
    logic [31:0] rd; int lat, wc; bit ok;
    // upper half of the store data must not reach the RAM
    do_access(1, 32'd0, 32'h5555_BEEF, 1'b1, 2'b01, rd, lat, wc, ok);
    do_access(1, 32'd1, 32'h0, 1'b0, 2'b00, rd, lat, wc, ok);
    n_checks++; if (rd !== 32'h0000_00BE) begin n_fail++; $display("FAIL half_byte_load: got %h want 000000be", rd); end
    do_access(1, 32'd0, 32'h0, 1'b0, 2'b10, rd, lat, wc, ok);
    n_checks++; if (rd !== 32'hAAAA_BEEF) begin n_fail++; $display("FAIL half_word_load: got %h want aaaabeef", rd); end
    do_access(1, 32'd1, 32'h0, 1'b0, 2'b01, rd, lat, wc, ok);
    n_checks++; if (rd !== 32'h0000_AABE) begin n_fail++; $display("FAIL half_unaligned_load: got %h want 0000aabe", rd); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_q[$];
    logic [1:0] exp_resp_q[$];
    logic [1:0] e;
    int overlap;
    apply_reset();
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_resp_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    overlap = 0;
    req_addr[0] = 32'd0; req_we[0] = 1'b0; req_size[0] = 2'b10;
    req_addr[1] = 32'd5; req_we[1] = 1'b0; req_size[1] = 2'b00;
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready == 2'b11) overlap++;
      if (req_ready != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL alt_extra_grant: got %b want none", req_ready);
        end else begin
          e = exp_q.pop_front();
          n_checks++; if (req_ready !== e) begin n_fail++; $display("FAIL alt_grant_order: got %b want %b", req_ready, e); end
        end
      end
      if (resp_valid != 2'b00) begin
        if (exp_resp_q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL alt_extra_resp: got %b want none", resp_valid);
        end else begin
          e = exp_resp_q.pop_front();
          n_checks++; if (resp_valid !== e) begin n_fail++; $display("FAIL alt_resp_port: got %b want %b", resp_valid, e); end
          if (e == 2'b01) begin
            n_checks++; if (resp_rdata_0 !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL alt_rdata0: got %h want aaaaaaaa", resp_rdata_0); end
          end else begin
            n_checks++; if (resp_rdata_1 !== 32'h0000_00AA) begin n_fail++; $display("FAIL alt_rdata1: got %h want 000000aa", resp_rdata_1); end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL alt_ready_overlap: got %0d want 0", overlap); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL alt_grant_count: missing %0d want 0", exp_q.size()); end
    n_checks++; if (exp_resp_q.size() != 0) begin n_fail++; $display("FAIL alt_resp_count: missing %0d want 0", exp_resp_q.size()); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; int lat, wc, pulses; bit ok, got_ready;
    apply_reset();
    got_ready = 1'b0; pulses = 0;
    req_addr[0] = 32'd4; req_wdata[0] = 32'h1234_5678; req_we[0] = 1'b1;
    req_size[0] = 2'b10; req_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin got_ready = 1'b1; break; end
    end
    n_checks++; if (got_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_handshake: got %b want 1", got_ready); end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_we: got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mem_addr: got %h want 00000000", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mem_wdata: got %h want 00000000", mem_wdata); end
    for (int k = 0; k < 3; k++) begin
      if (resp_valid != 2'b00) pulses++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rst_mid_no_resp: got %0d pulses want 0", pulses); end
    @(posedge clk);
    #1;
    do_access(1, 32'd4, 32'h0, 1'b0, 2'b10, rd, lat, wc, ok);
    n_checks++; if (ok !== 1'b1 || lat != 2) begin n_fail++; $display("FAIL rst_mid_next_req: got ok=%b lat=%0d want ok=1 lat=2", ok, lat); end
    n_checks++; if (rd !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL rst_mid_ram_untouched: got %h want aaaaaaaa", rd); end
  endtask

  task automatic test_abort();
    int bad_resp, bad_we, bad_ready;
    bad_resp = 0; bad_we = 0; bad_ready = 0;
    req_addr[1] = 32'd16; req_we[1] = 1'b0; req_size[1] = 2'b10; req_valid[1] = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL abort_p1_grant: got %b want 10", req_ready); end
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_addr[0] = 32'd12; req_wdata[0] = 32'hDEAD_BEEF; req_we[0] = 1'b1;
    req_size[0] = 2'b10; req_valid[0] = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL abort_ready_busy: got %b want 00", req_ready); end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_valid !== 2'b10) begin n_fail++; $display("FAIL abort_p1_resp: got %b want 10", resp_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) bad_resp++;
      if (mem_we) bad_we++;
      if (req_ready != 2'b00) bad_ready++;
    end
    n_checks++; if (bad_resp != 0) begin n_fail++; $display("FAIL abort_spurious_resp: got %0d want 0", bad_resp); end
    n_checks++; if (bad_we != 0 || bad_ready != 0) begin n_fail++; $display("FAIL abort_capture: got we=%0d ready=%0d want 0/0", bad_we, bad_ready); end
    n_checks++; if (mem_addr !== 32'd16) begin n_fail++; $display("FAIL abort_mem_addr: got %h want 00000010", mem_addr); end
    // last grant was port 1, so port 0 must win the contested cycle
    @(posedge clk);
    #1;
    req_addr[0] = 32'd16; req_we[0] = 1'b0;
    req_addr[1] = 32'd20; req_we[1] = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL abort_last_grant: got %b want 01", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_half_store();
    test_alternate();
    test_reset_mid_access();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
